// File: rtl/psum_drain_collector.sv
// Drains skewed per-column partial sums from the PE array top edge, realigns them
// into row vectors and queues them in a FIFO for the valid/ready writeback port.
module psum_drain_collector #(
  parameter int COLUMN_NUM = 8,
  parameter int ROW_NUM    = 8,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                           clk,
  input  logic                                           resetn,
  input  logic                                           drain_start,
  output logic                                           drain_start_ready,
  input  logic [COLUMN_NUM*OUT_W-1:0]                    b_output_stream,
  output logic [COLUMN_NUM-1:0]                          output_num_reg_en,
  output logic [COLUMN_NUM-1:0]                          output_num_reg_r0w1,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [COLUMN_NUM*OUT_W-1:0]                    out_data,
  output logic [(ROW_NUM > 1 ? $clog2(ROW_NUM) : 1)-1:0] out_row,
  output logic                                           out_last,
  output logic                                           busy
);

  // state | meaning
  // IDLE  | waiting for an accepted drain_start
  // DRAIN | k runs 0..COLUMN_NUM+ROW_NUM-2, capturing and pushing rows

  localparam int RW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int KW = $clog2(COLUMN_NUM + ROW_NUM);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int VW = COLUMN_NUM * OUT_W;
  localparam logic [KW-1:0] K_LAST = KW'(COLUMN_NUM + ROW_NUM - 2);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [VW-1:0]   aligned;
  logic            push, pop, push_last;
  logic [RW-1:0]   push_row;

  logic [VW-1:0]   mem_data [FIFO_DEPTH];
  logic [RW-1:0]   mem_row  [FIFO_DEPTH];
  logic            mem_last [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      S_IDLE: begin
        if (drain_start && drain_start_ready) begin
          state_nxt = S_DRAIN;
          k_nxt     = '0;
        end
      end
      S_DRAIN: begin
        k_nxt = k + KW'(1);
        if (k == K_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_DRAIN);

  // Free space uses the registered count, so a pop this cycle only helps next cycle.
  assign drain_start_ready = resetn && (state == S_IDLE) &&
                             ((CW'(FIFO_DEPTH) - count) >= CW'(ROW_NUM));

  assign output_num_reg_r0w1 = '0;

  for (genvar c = 0; c < COLUMN_NUM; c++) begin : g_col
    assign output_num_reg_en[c] = busy && (int'(k) >= c) && (int'(k) < c + ROW_NUM);

    if (c == COLUMN_NUM - 1) begin : g_live
      // Last column's row r arrives in the alignment cycle itself.
      assign aligned[c*OUT_W +: OUT_W] = b_output_stream[c*OUT_W +: OUT_W];
    end else begin : g_dly
      localparam int D = COLUMN_NUM - 1 - c;
      logic [OUT_W-1:0] pipe [D];

      always_ff @(posedge clk) begin
        if (!resetn) begin
          for (int i = 0; i < D; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= b_output_stream[c*OUT_W +: OUT_W];
          for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign aligned[c*OUT_W +: OUT_W] = pipe[D-1];
    end
  end

  assign push      = busy && (int'(k) >= COLUMN_NUM - 1);
  assign push_row  = RW'(k - KW'(COLUMN_NUM - 1));
  assign push_last = busy && (k == K_LAST);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push) begin
      mem_data[wr_ptr] <= aligned;
      mem_row[wr_ptr]  <= push_row;
      mem_last[wr_ptr] <= push_last;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_row   = out_valid ? mem_row[rd_ptr]  : '0;
  assign out_last  = out_valid && mem_last[rd_ptr];

endmodule

// File: tb/tb_psum_drain_collector.sv
// Randomized bench for psum_drain_collector: a cycle-indexed array/FIFO model
// predicts every output each cycle, plus directed checks of the key scenarios.
module tb_psum_drain_collector;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int VW = N * W;

  logic          clk = 1'b0;
  logic          resetn;
  logic          drain_start;
  logic          drain_start_ready;
  logic [VW-1:0] b_output_stream;
  logic [N-1:0]  output_num_reg_en;
  logic [N-1:0]  output_num_reg_r0w1;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic [1:0]    out_row;
  logic          out_last;
  logic          busy;

  always #5 clk = ~clk;

  psum_drain_collector #(.COLUMN_NUM(N), .ROW_NUM(R), .OUT_W(W), .FIFO_DEPTH(D)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .drain_start         (drain_start),
    .drain_start_ready   (drain_start_ready),
    .b_output_stream     (b_output_stream),
    .output_num_reg_en   (output_num_reg_en),
    .output_num_reg_r0w1 (output_num_reg_r0w1),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .out_row             (out_row),
    .out_last            (out_last),
    .busy                (busy)
  );

  typedef struct { int due; logic [VW-1:0] data; int row; bit last; } ent_t;
  typedef struct { logic [VW-1:0] d; logic [1:0] r; logic l; } pop_t;

  ent_t        pend[$];
  ent_t        q[$];
  pop_t        dpops[$];
  logic [15:0] cur [R][N];
  logic [15:0] nxt [R][N];
  int          cyc, t_acc, n_acc;
  bit          active;
  int          checks, failures;
  int          first_valid, busy_cnt, en3_cnt;
  logic [VW-1:0] head;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_busy();
    return active && (cyc <= t_acc + N + R - 2);
  endfunction

  function automatic bit m_ready();
    return resetn && !m_busy() && ((D - q.size()) >= R);
  endfunction

  task automatic rand_nxt();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < N; c++) nxt[r][c] = 16'($urandom);
  endtask

  task automatic clear_stats();
    dpops.delete();
    first_valid = -1;
    busy_cnt    = 0;
    en3_cnt     = 0;
  endtask

  task automatic tick();
    int    k;
    bit    acc, pop;
    logic [N-1:0] exp_en;
    ent_t  e;
    pop_t  p;
    k = cyc - t_acc;
    for (int c = 0; c < N; c++) begin
      if (m_busy() && (k - c >= 0) && (k - c < R)) b_output_stream[c*W +: W] = cur[k-c][c];
      else                                         b_output_stream[c*W +: W] = 16'($urandom);
    end
    #1;
    for (int c = 0; c < N; c++) exp_en[c] = m_busy() && (k >= c) && (k < c + R);
    check_val("busy", 64'(busy), 64'(m_busy()));
    check_val("start_ready", 64'(drain_start_ready), 64'(m_ready()));
    check_val("reg_en", 64'(output_num_reg_en), 64'(exp_en));
    check_val("reg_r0w1", 64'(output_num_reg_r0w1), 64'(0));
    check_val("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check_val("out_data", out_data, q[0].data);
      check_val("out_row", 64'(out_row), 64'(q[0].row));
      check_val("out_last", 64'(out_last), 64'(q[0].last));
    end
    if (out_valid && first_valid < 0) first_valid = cyc - t_acc + 1;
    busy_cnt += int'(busy);
    en3_cnt  += int'(output_num_reg_en[3]);
    if (resetn && out_valid && out_ready) begin
      p.d = out_data; p.r = out_row; p.l = out_last;
      dpops.push_back(p);
    end
    acc = drain_start && m_ready();
    pop = resetn && (q.size() != 0) && out_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (!resetn) begin
      q.delete();
      pend.delete();
      active = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      while (pend.size() != 0 && pend[0].due == cyc) q.push_back(pend.pop_front());
      if (acc) begin
        active = 1'b1;
        t_acc  = cyc;
        n_acc++;
        cur = nxt;
        for (int r = 0; r < R; r++) begin
          e.due  = cyc + N + r;
          e.row  = r;
          e.last = (r == R - 1);
          for (int c = 0; c < N; c++) e.data[c*W +: W] = cur[r][c];
          pend.push_back(e);
        end
        rand_nxt();
      end
    end
  endtask

  task automatic idle(input int n);
    drain_start = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_tile();
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
  endtask

  initial begin
    int acc0;
    checks = 0; failures = 0; cyc = 0; t_acc = -100; n_acc = 0; active = 1'b0;
    resetn = 1'b0; drain_start = 1'b0; out_ready = 1'b0;
    b_output_stream = '0;
    rand_nxt();
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    tick();
    check_val("rst_valid", 64'(out_valid), 64'(0));
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_en", 64'(output_num_reg_en), 64'(0));
    check_val("rst_data", out_data, 64'(0));
    check_val("rst_ready", 64'(drain_start_ready), 64'(0));
    resetn = 1'b1;
    #1;
    check_val("rst_rel_ready", 64'(drain_start_ready), 64'(1));

    // Structured tile 16*r+c, sink always ready
    for (int r = 0; r < R; r++)
      for (int c = 0; c < N; c++) nxt[r][c] = 16'(16*r + c);
    out_ready = 1'b1;
    idle(1);
    clear_stats();
    start_tile();
    idle(12);
    check_val("first_valid_lat", 64'(first_valid), 64'(N + 1));
    check_val("busy_cycles", 64'(busy_cnt), 64'(N + R - 1));
    check_val("en3_cycles", 64'(en3_cnt), 64'(R));
    check_val("pop_count", 64'(dpops.size()), 64'(R));
    if (dpops.size() == R) begin
      check_val("row2_data", dpops[2].d, 64'h0023_0022_0021_0020);
      check_val("last_pattern", 64'({dpops[3].l, dpops[2].l, dpops[1].l, dpops[0].l}), 64'(4'b1000));
      for (int i = 0; i < R; i++) check_val("row_order", 64'(dpops[i].r), 64'(i));
    end

    // Start pulse during drain must be ignored
    clear_stats();
    acc0 = n_acc;
    start_tile();
    idle(2);
    start_tile();
    idle(12);
    check_val("ignored_start_tiles", 64'(n_acc - acc0), 64'(1));
    check_val("ignored_start_pops", 64'(dpops.size()), 64'(R));

    // Backpressure: two tiles fill the 8-entry FIFO
    out_ready = 1'b0;
    start_tile();
    idle(8);
    start_tile();
    idle(10);
    check_val("bp_full_ready", 64'(drain_start_ready), 64'(0));
    check_val("bp_full_valid", 64'(out_valid), 64'(1));
    head = out_data;
    idle(5);
    check_val("bp_head_stable", out_data, head);
    out_ready = 1'b1; tick(); out_ready = 1'b0; tick();
    check_val("bp_ready_1pop", 64'(drain_start_ready), 64'(0));
    out_ready = 1'b1; tick(); tick(); tick(); out_ready = 1'b0; tick();
    check_val("bp_ready_4pop", 64'(drain_start_ready), 64'(1));
    out_ready = 1'b1;
    idle(8);

    // Sign-bit patterns pass bit-exact
    rand_nxt();
    for (int r = 0; r < R; r++) begin nxt[r][1] = 16'h8000; nxt[r][2] = 16'hFFFF; end
    clear_stats();
    start_tile();
    idle(12);
    check_val("neg_pop_count", 64'(dpops.size()), 64'(R));
    foreach (dpops[i]) begin
      check_val("neg_col1", 64'(dpops[i].d[1*W +: W]), 64'h8000);
      check_val("neg_col2", 64'(dpops[i].d[2*W +: W]), 64'hFFFF);
    end

    // Reset at k=3 abandons the tile
    out_ready = 1'b0;
    start_tile();
    idle(3);
    resetn = 1'b0;
    tick();
    check_val("mid_rst_valid", 64'(out_valid), 64'(0));
    check_val("mid_rst_busy", 64'(busy), 64'(0));
    check_val("mid_rst_en", 64'(output_num_reg_en), 64'(0));
    resetn = 1'b1;
    #1;
    check_val("mid_rst_ready", 64'(drain_start_ready), 64'(1));
    out_ready = 1'b1;
    clear_stats();
    start_tile();
    idle(12);
    check_val("mid_rst_fresh_pops", 64'(dpops.size()), 64'(R));

    // Random traffic including back-to-back starts
    for (int i = 0; i < 400; i++) begin
      drain_start = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain_start = 1'b0;
    out_ready   = 1'b1;
    idle(30);
    check_val("final_empty", 64'(out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
